// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcode values
// driven by decode and the FSM state enum used by the top.
package mul_div_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/sign_fix.sv
// Conditional two's-complement negate. Used as |x| at operand entry
// (neg = sign bit) and as the sign application step on the way out.
module sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_val,
  input  logic         neg,
  output logic [W-1:0] out_val
);

  // Negate only when requested; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    out_val = neg ? ('0 - in_val) : in_val;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit. Shift-add multiply and
// restoring divide, one bit per cycle, plus MTHI/MTLO writes.
// Optional feature macro: SIGNED_OPS_EN (signed MULT/DIV via a FIX state).
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   b_q, b_d;       // multiplicand or divisor
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   a_op, b_op;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rem_ext;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

`ifdef SIGNED_OPS_EN
  logic               neg_p_q, neg_p_d;   // product / quotient takes a minus sign
  logic               neg_r_q, neg_r_d;   // remainder follows the dividend sign
  logic               is_div_q, is_div_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  sign_fix #(.W(WIDTH)) u_abs_a (
    .in_val(rs_content), .neg(signed_op & rs_content[WIDTH-1]), .out_val(a_op));
  sign_fix #(.W(WIDTH)) u_abs_b (
    .in_val(rt_content), .neg(signed_op & rt_content[WIDTH-1]), .out_val(b_op));
  sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .in_val(acc_q), .neg(neg_p_q), .out_val(prod_fix));
  sign_fix #(.W(WIDTH)) u_fix_quo (
    .in_val(acc_q[WIDTH-1:0]), .neg(neg_p_q), .out_val(quo_fix));
  sign_fix #(.W(WIDTH)) u_fix_rem (
    .in_val(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_r_q), .out_val(rem_fix));
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign a_op = rs_content;
  assign b_op = rt_content;
`endif

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign accept      = start && !busy;
  assign last_iter   = (cnt_q == CW'(WIDTH - 1));

  // One iteration step of both datapaths; the FSM picks which one to keep.
  always_comb begin
    mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
    mul_next    = {mul_sum, acc_q[WIDTH-1:1]};
    div_rem_ext = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge      = div_rem_ext >= {1'b0, b_q};
    // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
    div_diff    = div_rem_ext[WIDTH-1:0] - b_q;
    div_next    = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                         : {acc_q[2*WIDTH-2:0], 1'b0};
  end

  // Next-state, iteration and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_OPS_EN
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    is_div_d = is_div_q;
`endif

    case (state_q)
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
`ifdef SIGNED_OPS_EN
          state_d = S_FIX;
`else
          {hi_d, lo_d} = mul_next;
          state_d      = S_DONE;
`endif
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
`ifdef SIGNED_OPS_EN
          state_d = S_FIX;
`else
          hi_d    = div_next[2*WIDTH-1:WIDTH];
          lo_d    = div_next[WIDTH-1:0];
          state_d = S_DONE;
`endif
        end
      end
      S_FIX: begin
`ifdef SIGNED_OPS_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = S_DONE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Accept in IDLE or DONE (back-to-back); overrides the DONE->IDLE step.
    if (accept) begin
      dbz_d = 1'b0;
      cnt_d = '0;
`ifdef SIGNED_OPS_EN
      neg_p_d  = signed_op & (rs_content[WIDTH-1] ^ rt_content[WIDTH-1]);
      neg_r_d  = signed_op & rs_content[WIDTH-1];
      is_div_d = (op_e'(op) == OP_DIV);
`endif
      case (op_e'(op))
        OP_MUL: begin
          acc_d   = {{WIDTH{1'b0}}, b_op};
          b_d     = a_op;
          state_d = S_MUL;
        end
        OP_DIV: begin
          if (rt_content == '0) begin
            lo_d    = '1;
            hi_d    = rs_content;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, a_op};
            b_d     = b_op;
            state_d = S_DIV;
          end
        end
        OP_MTHI: begin
          hi_d    = rs_content;
          state_d = S_DONE;
        end
        default: begin
          lo_d    = rs_content;
          state_d = S_DONE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_OPS_EN
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_OPS_EN
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      is_div_q <= is_div_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit plus hand sequences for
// busy-ignore, mid-operation reset and back-to-back issue.
module tb_mul_div_unit;
  import mul_div_pkg::*;

`ifdef SIGNED_OPS_EN
  localparam int LAT_MD = 34;
`else
  localparam int LAT_MD = 33;
`endif
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n, start, signed_op, busy, done, div_by_zero;
  logic [1:0]  op;
  logic [31:0] rs_content, rt_content, hi, lo;

  int n_pass = 0;
  int n_total = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .signed_op(signed_op),
    .rs_content(rs_content), .rt_content(rt_content), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        sg;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Issue one op at the next edge and wait (bounded) for done; returns at
  // edge+1 inside the done cycle. lat==1 means done right after the accept edge.
  task automatic run_op(input logic [1:0] o, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    op = o; signed_op = s; rs_content = a; rt_content = b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 1;
    while (!done && lat < TMO) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  vec_t vecs[$];
  int   lat;

  initial begin
    vecs.push_back('{OP_MUL,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT_MD});
    vecs.push_back('{OP_MUL,  1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, LAT_MD});
    vecs.push_back('{OP_MUL,  1'b0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, LAT_MD});
    vecs.push_back('{OP_MUL,  1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, LAT_MD});
    vecs.push_back('{OP_DIV,  1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, LAT_MD});
    vecs.push_back('{OP_DIV,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, LAT_MD});
    vecs.push_back('{OP_DIV,  1'b0, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1});
    vecs.push_back('{OP_DIV,  1'b0, 32'd3,        32'd10,       32'd3,        32'd0,        1'b0, LAT_MD});
    vecs.push_back('{OP_MTHI, 1'b0, 32'h00001234, 32'h0,        32'h00001234, 32'd0,        1'b0, 1});
    vecs.push_back('{OP_MTLO, 1'b0, 32'h0000ABCD, 32'h0,        32'h00001234, 32'h0000ABCD, 1'b0, 1});
    vecs.push_back('{OP_DIV,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, LAT_MD});
`ifdef SIGNED_OPS_EN
    vecs.push_back('{OP_MUL,  1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34});
    vecs.push_back('{OP_DIV,  1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34});
    vecs.push_back('{OP_DIV,  1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34});
    vecs.push_back('{OP_DIV,  1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1});
`endif

    rst_n = 1'b0; start = 1'b0; op = 2'b00; signed_op = 1'b0;
    rs_content = 32'h0; rt_content = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi",   64'(hi),   64'd0);
    chk("reset_lo",   64'(lo),   64'd0);
    chk("reset_dbz",  64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_lat", i),  64'(lat),  64'(vecs[i].lat));
      chk($sformatf("v%0d_hi", i),   64'(hi),   64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i),   64'(lo),   64'(vecs[i].lo));
      chk($sformatf("v%0d_dbz", i),  64'(div_by_zero), 64'(vecs[i].dbz));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      @(posedge clk); #1;
    end

    // div_by_zero stays set across idle cycles until the next accepted start
    run_op(OP_DIV, 1'b0, 32'd9, 32'd0, lat);
    repeat (3) @(posedge clk);
    #1;
    chk("dbz_sticky", 64'(div_by_zero), 64'd1);
    chk("dbz_hi_held", 64'(hi), 64'd9);
    run_op(OP_MTLO, 1'b0, 32'h77, 32'h0, lat);
    chk("dbz_cleared", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;

    // Start while busy is ignored; operand changes have no effect; HI/LO held
    run_op(OP_MTHI, 1'b0, 32'hAAAA, 32'h0, lat);
    run_op(OP_MTLO, 1'b0, 32'hBBBB, 32'h0, lat);
    op = OP_MUL; signed_op = 1'b0; rs_content = 32'd3; rt_content = 32'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 1;
    while (!done && lat < TMO) begin
      if (lat == 5) begin
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_hi", 64'(hi), 64'hAAAA);
        chk("mid_lo", 64'(lo), 64'hBBBB);
        op = OP_MTHI; rs_content = 32'h9999; rt_content = 32'h0; start = 1'b1;
      end
      @(posedge clk); #1; start = 1'b0; lat++;
    end
    chk("ign_lat", 64'(lat), 64'(LAT_MD));
    chk("ign_hi",  64'(hi),  64'd0);
    chk("ign_lo",  64'(lo),  64'd12);
    @(posedge clk); #1;
    chk("ign_no_extra_done", 64'(done), 64'd0);
    chk("ign_hi_after", 64'(hi), 64'd0);

    // Back-to-back: start during the done cycle is accepted
    run_op(OP_MTHI, 1'b0, 32'h55, 32'h0, lat);
    op = OP_MTLO; rs_content = 32'h66; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_hi", 64'(hi), 64'h55);
    chk("b2b_lo", 64'(lo), 64'h66);
    @(posedge clk); #1;

    // Reset ten cycles into a MUL aborts it with no done pulse
    op = OP_MUL; rs_content = 32'd7; rt_content = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done) seen++;
        @(posedge clk); #1;
      end
      chk("rst_no_done", 64'(seen), 64'd0);
    end

    // Unit is usable again after the abort
    run_op(OP_MUL, 1'b0, 32'd6, 32'd7, lat);
    chk("post_rst_lat", 64'(lat), 64'(LAT_MD));
    chk("post_rst_lo", 64'(lo), 64'd42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
